// File: rtl/speed_level_controller.sv
// speed_level_controller: 4-level speed selector with edge-triggered buttons, e-stop stepping and ramp hold
module speed_level_controller #(
  parameter int RAMP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       e_stop,
  output logic [1:0] vel_code,
  output logic       busy,
  output logic       changed,
  output logic       at_max,
  output logic       at_min,
  output logic       stopped
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t     state;
  logic [1:0] level;
  logic [7:0] cnt;
  logic       up_q, dn_q, es_q;
  logic       up_edge, dn_edge, go_up, go_dn;
  assign up_edge  = btn_up & ~up_q;
  assign dn_edge  = btn_down & ~dn_q;
  assign go_dn    = level != 2'd0 && (e_stop || (dn_edge && !up_edge));
  assign go_up    = !e_stop && up_edge && !dn_edge && level != 2'd3;
  assign vel_code = level;
  assign at_max   = level == 2'd3;
  assign at_min   = level == 2'd0;
  assign stopped  = es_q && level == 2'd0;
  // Edge history, level commits and the ramp hold timer; buttons ignored outside IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      level   <= 2'd0;
      cnt     <= 8'd0;
      busy    <= 1'b0;
      changed <= 1'b0;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
      es_q    <= e_stop;
    end else begin
      up_q    <= btn_up;
      dn_q    <= btn_down;
      es_q    <= e_stop;
      changed <= 1'b0;
      if (state == IDLE) begin
        if (go_dn || go_up) begin
          level   <= go_dn ? level - 2'd1 : level + 2'd1;
          state   <= HOLD;
          cnt     <= 8'(RAMP_CYCLES - 1);
          busy    <= 1'b1;
          changed <= 1'b1;
        end
      end else if (cnt == 8'd0) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end
endmodule
